// File: rtl/data_mem_dumper.sv
// data_mem_dumper: walks every data memory word through the debug read port,
// snapshots it, and streams it LSB byte first over a valid/ready TX handshake.
module data_mem_dumper #(
    parameter int B = 32,   // word width in bits, multiple of 8
    parameter int W = 5     // word-address width
) (
    input  logic         i_clk,
    input  logic         i_reset_n,
    input  logic         i_start,
    input  logic [B-1:0] i_debug_mem,
    input  logic         i_tx_ready,
    output logic [W-1:0] o_debug_addr,
    output logic [7:0]   o_tx_data,
    output logic         o_tx_valid,
    output logic         o_busy,
    output logic         o_done
);
    localparam int NBYTES = B / 8;
    localparam int BW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] LAST_BYTE = BW'(NBYTES - 1);
    localparam logic [W-1:0]  LAST_ADDR = {W{1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SEND, S_DONE} state_t;

    state_t        r_state;
    state_t        w_next;
    logic [B-1:0]  r_word;
    logic [BW-1:0] r_byte_idx;
    logic [W-1:0]  r_addr;
    logic          w_hs;
    logic          w_last_byte;
    logic          w_last_addr;

    // Handshake only ever happens in SEND, where valid is asserted.
    assign w_hs        = (r_state == S_SEND) && i_tx_ready;
    assign w_last_byte = (r_byte_idx == LAST_BYTE);
    assign w_last_addr = (r_addr == LAST_ADDR);

    // State register.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) r_state <= S_IDLE;
        else            r_state <= w_next;
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_start) w_next = S_LOAD;
            S_LOAD: w_next = S_SEND;
            S_SEND: if (w_hs && w_last_byte) w_next = w_last_addr ? S_DONE : S_LOAD;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Datapath: address counter, word snapshot and byte index.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_addr     <= '0;
            r_word     <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (i_start) r_addr <= '0;
                S_LOAD: begin
                    r_word     <= i_debug_mem;
                    r_byte_idx <= '0;
                end
                S_SEND: if (w_hs) begin
                    if (!w_last_byte)      r_byte_idx <= r_byte_idx + 1'b1;
                    else if (!w_last_addr) r_addr     <= r_addr + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only; nothing depends on i_tx_ready.
    always_comb begin
        o_debug_addr = r_addr;
        o_tx_data    = 8'h00;
        o_tx_valid   = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_LOAD: o_busy = 1'b1;
            S_SEND: begin
                o_busy     = 1'b1;
                o_tx_valid = 1'b1;
                o_tx_data  = r_word[{r_byte_idx, 3'b000} +: 8];
            end
            S_DONE: o_done = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_data_mem_dumper.sv
// Directed bench for data_mem_dumper: default (B=32,W=5) and small (B=16,W=2) instances.
module tb_data_mem_dumper;
    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic        i_tx_ready = 1'b0;
    logic [31:0] w_mem_rd;
    logic [4:0]  o_debug_addr;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid, o_busy, o_done;

    logic        s_start = 1'b0;
    logic        s_ready = 1'b0;
    logic [15:0] s_mem_rd;
    logic [1:0]  s_addr;
    logic [7:0]  s_data;
    logic        s_valid, s_busy, s_done;

    logic [31:0] mem [32];
    logic [31:0] golden [32];
    logic [15:0] mem16 [4];

    int checks = 0;
    int failures = 0;

    // results of the last dump run
    logic [7:0] got [$];
    logic [7:0] expq [$];
    int done_cnt, done_cyc, busy_bad, stab_bad, first_vld;

    assign w_mem_rd = mem[o_debug_addr];
    assign s_mem_rd = mem16[s_addr];

    always #5 i_clk = ~i_clk;

    data_mem_dumper #(.B(32), .W(5)) u_dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(i_start),
        .i_debug_mem(w_mem_rd), .i_tx_ready(i_tx_ready),
        .o_debug_addr(o_debug_addr), .o_tx_data(o_tx_data),
        .o_tx_valid(o_tx_valid), .o_busy(o_busy), .o_done(o_done)
    );

    data_mem_dumper #(.B(16), .W(2)) u_small (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .i_start(s_start),
        .i_debug_mem(s_mem_rd), .i_tx_ready(s_ready),
        .o_debug_addr(s_addr), .o_tx_data(s_data),
        .o_tx_valid(s_valid), .o_busy(s_busy), .o_done(s_done)
    );

    // Expected stream from the golden image (optionally with word 5 replaced).
    task automatic build_exp(input bit patch5);
        logic [31:0] wv;
        expq.delete();
        for (int k = 0; k < 32; k++) begin
            wv = (patch5 && k == 5) ? 32'hDEADBEEF : golden[k];
            for (int b = 0; b < 4; b++) expq.push_back(wv[8*b +: 8]);
        end
    endtask

    function automatic int first_mismatch();
        if (got.size() != expq.size()) return (got.size() < expq.size()) ? got.size() : expq.size();
        for (int i = 0; i < got.size(); i++) if (got[i] !== expq[i]) return i;
        return -1;
    endfunction

    // Run one dump on the default DUT. mode 0: ready=1, mode 1: random ready.
    // start2: cycle at which i_start is pulsed again; wr: cycle with ready=0 and
    // memory writes to words 3 and 5. Collects bytes and observations, no checks.
    task automatic run_dump(input int mode, input int start2, input int wr, input int max_cyc);
        int cyc;
        bit prev_stall;
        logic [7:0] prev_data;
        logic rdy;
        got.delete();
        done_cnt = 0; done_cyc = -1; busy_bad = 0; stab_bad = 0; first_vld = -1;
        prev_stall = 0; prev_data = 8'h00;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        cyc = 1;
        while (cyc <= max_cyc) begin
            rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (cyc == wr) begin
                rdy = 1'b0;
                mem[3] = 32'hDEADBEEF;
                mem[5] = 32'hDEADBEEF;
            end
            i_tx_ready = rdy;
            i_start = (cyc == start2);
            if (prev_stall && (o_tx_valid !== 1'b1 || o_tx_data !== prev_data)) stab_bad++;
            if (o_done === 1'b1) begin done_cnt++; done_cyc = cyc; end
            if (mode == 0 && o_busy !== ((cyc >= 1 && cyc <= 160) ? 1'b1 : 1'b0)) busy_bad++;
            if (o_tx_valid === 1'b1 && first_vld < 0) first_vld = cyc;
            if (o_tx_valid === 1'b1 && rdy) got.push_back(o_tx_data);
            prev_stall = (o_tx_valid === 1'b1) && !rdy;
            prev_data  = o_tx_data;
            if (done_cnt > 0 && cyc >= done_cyc + 3) break;
            @(posedge i_clk); #1;
            cyc++;
        end
        i_start = 1'b0;
        i_tx_ready = 1'b0;
    endtask

    task automatic test_reset;
        i_reset_n = 1'b0; i_start = 1'b1; s_start = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if ({o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done} !== 16'h0) begin
            failures++;
            $display("FAIL reset_outputs got addr=%0d data=%h v=%b busy=%b done=%b want all 0",
                     o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done);
        end
        checks++;
        if ({s_addr, s_data, s_valid, s_busy, s_done} !== 13'h0) begin
            failures++;
            $display("FAIL reset_outputs_small got addr=%0d data=%h v=%b busy=%b done=%b want all 0",
                     s_addr, s_data, s_valid, s_busy, s_done);
        end
        i_start = 1'b0; s_start = 1'b0;
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        @(posedge i_clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_tx_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset got busy=%b valid=%b want 0 0", o_busy, o_tx_valid);
        end
    endtask

    task automatic test_sequential;
        int mi;
        build_exp(0);
        run_dump(0, -1, -1, 400);
        mi = first_mismatch();
        checks++;
        if (got.size() != 128) begin failures++; $display("FAIL seq_count got %0d want 128", got.size()); end
        checks++;
        if (mi >= 0) begin failures++; $display("FAIL seq_stream at byte %0d got %h want %h", mi, got[mi], expq[mi]); end
        checks++;
        if (first_vld != 2) begin failures++; $display("FAIL seq_first_valid got cycle %0d want 2", first_vld); end
        checks++;
        if (done_cnt != 1 || done_cyc != 161) begin
            failures++; $display("FAIL seq_done got count=%0d cycle=%0d want 1 at 161", done_cnt, done_cyc);
        end
        checks++;
        if (busy_bad != 0) begin failures++; $display("FAIL seq_busy got %0d bad cycles want 0", busy_bad); end
        checks++;
        if (o_debug_addr !== 5'd31) begin failures++; $display("FAIL seq_addr_hold got %0d want 31", o_debug_addr); end
    endtask

    task automatic test_backpressure;
        int mi;
        build_exp(0);
        run_dump(1, -1, -1, 2000);
        mi = first_mismatch();
        checks++;
        if (got.size() != 128) begin failures++; $display("FAIL bp_count got %0d want 128", got.size()); end
        checks++;
        if (mi >= 0) begin failures++; $display("FAIL bp_stream at byte %0d got %h want %h", mi, got[mi], expq[mi]); end
        checks++;
        if (stab_bad != 0) begin failures++; $display("FAIL bp_stable got %0d unstable stalls want 0", stab_bad); end
        checks++;
        if (done_cnt != 1) begin failures++; $display("FAIL bp_done got %0d pulses want 1", done_cnt); end
    endtask

    task automatic test_start_while_busy;
        int mi;
        build_exp(0);
        run_dump(0, 40, -1, 400);
        mi = first_mismatch();
        checks++;
        if (got.size() != 128 || mi >= 0) begin
            failures++; $display("FAIL busy_start_stream got count=%0d first_bad=%0d want 128 and -1", got.size(), mi);
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 161) begin
            failures++; $display("FAIL busy_start_done got count=%0d cycle=%0d want 1 at 161", done_cnt, done_cyc);
        end
        // a start landing in the DONE cycle must not relaunch the dump
        run_dump(0, 161, -1, 400);
        checks++;
        if (busy_bad != 0 || done_cnt != 1) begin
            failures++; $display("FAIL done_start_ignored got busy_bad=%0d done=%0d want 0 1", busy_bad, done_cnt);
        end
    endtask

    task automatic test_mid_reset;
        int mi;
        i_start = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0;
        i_tx_ready = 1'b1;
        for (int c = 1; c < 50; c++) begin @(posedge i_clk); #1; end
        i_reset_n = 1'b0;
        @(posedge i_clk); #1;
        i_reset_n = 1'b1;
        i_tx_ready = 1'b0;
        checks++;
        if ({o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done} !== 16'h0) begin
            failures++;
            $display("FAIL midreset_outputs got addr=%0d data=%h v=%b busy=%b done=%b want all 0",
                     o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done);
        end
        @(posedge i_clk); #1;
        checks++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            failures++; $display("FAIL midreset_idle got busy=%b done=%b want 0 0", o_busy, o_done);
        end
        build_exp(0);
        run_dump(0, -1, -1, 400);
        mi = first_mismatch();
        checks++;
        if (got.size() != 128 || mi >= 0 || first_vld != 2) begin
            failures++;
            $display("FAIL midreset_restart got count=%0d first_bad=%0d first_valid=%0d want 128 -1 2",
                     got.size(), mi, first_vld);
        end
    endtask

    task automatic test_snapshot;
        int mi;
        build_exp(1);
        run_dump(0, -1, 18, 400);
        mi = first_mismatch();
        checks++;
        if (got.size() != 128) begin failures++; $display("FAIL snap_count got %0d want 128", got.size()); end
        checks++;
        if (mi >= 0) begin failures++; $display("FAIL snap_stream at byte %0d got %h want %h", mi, got[mi], expq[mi]); end
        checks++;
        if (stab_bad != 0) begin failures++; $display("FAIL snap_stable got %0d want 0", stab_bad); end
        for (int k = 0; k < 32; k++) mem[k] = golden[k];
    endtask

    task automatic test_small_params;
        logic [7:0] sg [$];
        logic [7:0] se [8];
        int sdone;
        int bad;
        for (int k = 0; k < 4; k++) begin
            se[2*k]   = 8'hB0 + 8'(k);
            se[2*k+1] = 8'hA0;
        end
        sdone = -1;
        s_start = 1'b1;
        @(posedge i_clk); #1;
        s_start = 1'b0;
        s_ready = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            if (s_done === 1'b1 && sdone < 0) sdone = c;
            if (s_valid === 1'b1) sg.push_back(s_data);
            @(posedge i_clk); #1;
        end
        s_ready = 1'b0;
        checks++;
        if (sg.size() != 8) begin failures++; $display("FAIL small_count got %0d want 8", sg.size()); end
        bad = 0;
        for (int i = 0; i < 8 && i < sg.size(); i++) if (sg[i] !== se[i]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL small_stream got %0d wrong bytes want 0", bad); end
        checks++;
        if (sdone != 13) begin failures++; $display("FAIL small_done got cycle %0d want 13", sdone); end
    endtask

    initial begin
        for (int k = 0; k < 32; k++) begin
            golden[k] = 32'h11223344 + 32'(k);
            mem[k]    = golden[k];
        end
        for (int k = 0; k < 4; k++) mem16[k] = 16'hA0B0 + 16'(k);
        test_reset();
        test_sequential();
        test_backpressure();
        test_start_while_busy();
        test_mid_reset();
        test_snapshot();
        test_small_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case a run never terminates.
    initial begin
        #2000000;
        $display("FAIL timeout got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_dumper.md
# data_mem_dumper

Debug-side reader for the data memory. On a start request it walks every data memory word through the memory's debug read port, snapshots each word, and streams it byte by byte, least significant byte first, to the debugger's UART transmitter over a valid/ready handshake. It sits between the data memory's debug address/data pair and the debug unit's TX path, and is the read-out counterpart of the store path that fills the memory.

## Interface
Parameters:
- B, 32, data memory word width in bits; must be a multiple of 8.
- W, 5, data memory word-address width; the memory holds 2**W words.

Ports:
- i_clk, input, 1, clock; all state changes on the rising edge.
- i_reset_n, input, 1, reset, synchronous and active-low.
- i_start, input, 1, dump request; sampled only in IDLE.
- i_debug_mem, input, B, word read from the data memory's debug port; combinational from o_debug_addr.
- i_tx_ready, input, 1, the transmitter can accept a byte this cycle.
- o_debug_addr, output, W, word address driven to the data memory's debug port.
- o_tx_data, output, 8, byte presented to the transmitter.
- o_tx_valid, output, 1, o_tx_data is valid.
- o_busy, output, 1, a dump is in progress (LOAD or SEND).
- o_done, output, 1, one-cycle pulse when the dump completes.

## Operation
- Reset (i_reset_n=0 at an edge): state=IDLE. All outputs return to 0: o_debug_addr, o_tx_data, o_tx_valid, o_busy, o_done. The word register and byte index also clear.
- IDLE: if i_start=1, set o_debug_addr<=0 and go to LOAD. Otherwise stay in IDLE.
- LOAD: word_reg<=i_debug_mem (the whole word is snapshot at once), byte_idx<=0, go to SEND.
- SEND: o_tx_valid=1 and o_tx_data=word_reg[8*byte_idx +: 8].
  - A handshake occurs on an edge where o_tx_valid=1 and i_tx_ready=1.
  - If byte_idx<B/8-1, byte_idx increments.
  - If byte_idx=B/8-1 and o_debug_addr<2**W-1, o_debug_addr increments and the state goes to LOAD.
  - If byte_idx=B/8-1 and o_debug_addr=2**W-1, the state goes to DONE.
- DONE: o_done=1 for exactly one cycle, then IDLE. o_debug_addr holds 2**W-1 until the next start.
- o_busy=1 exactly in LOAD and SEND.
- Byte order on the wire: word 0 byte 0 (bits 7:0), word 0 byte 1, and so on up to word 2**W-1 byte B/8-1. Total bytes sent: 2**W*B/8 (128 with the defaults).
- Arithmetic: o_debug_addr is a W-bit counter that never wraps during a dump; the last-word compare ends the dump. byte_idx is a clog2(B/8)-bit counter (minimum 1 bit).

## Timing
- Take the start edge (IDLE, i_start=1) as edge 0. LOAD is active in cycle 1. The first byte is valid in cycle 2.
- With i_tx_ready held at 1, each word costs 1+B/8 cycles (5 with the defaults).
  - Word n: LOAD in cycle 1+5n, SEND in cycles 2+5n to 5+5n.
  - The last SEND is cycle 160. o_done=1 and o_busy=0 in cycle 161. IDLE resumes in cycle 162.
- Handshake rule: while o_tx_valid=1 and i_tx_ready=0, o_tx_data, byte_idx and o_debug_addr hold unchanged. o_tx_valid never drops before its handshake.
- o_tx_valid is 0 in LOAD, so there is one bubble cycle between words.
- i_start while busy or in DONE is ignored; there is no queued restart. A fresh i_start in IDLE restarts the dump from word 0.
- If memory is written during a dump, the bytes of a word already loaded stay from that snapshot. Words not yet loaded reflect their content at their own LOAD cycle.
- Reset mid-dump (any state): at the next edge the state is IDLE, all outputs are 0, and no o_done is pulsed.
- All outputs are registered or decoded from registered state only. There is no combinational path from i_tx_ready to any output.

## Test plan
- Sequential dump: preload word k=0x11223344+k for k=0..31, hold i_tx_ready=1, pulse i_start -> 128 bytes arrive in order 44,33,22,11,45,33,22,11,… ; o_done pulses in cycle 161; o_busy is high in cycles 1-160.
- Backpressure: toggle i_tx_ready pseudo-randomly (about 50%) -> identical byte stream; o_tx_data and o_tx_valid are stable on every cycle with ready=0; exactly 128 handshakes.
- Start while busy: pulse i_start again in cycle 40 -> no effect; exactly one o_done; byte count 128.
- Mid-dump reset: drive i_reset_n=0 at cycle 50 -> next cycle all outputs are 0 and the state is IDLE. A following i_start restarts the dump at word 0, byte 0.
- Snapshot consistency: write word 3 to 0xDEADBEEF while word 3 is in SEND with ready=0 -> the old bytes of word 3 are still sent. Write word 5 before its LOAD -> EF,BE,AD,DE are sent for word 5.
- Parameter sweep: B=16, W=2 -> 8 bytes, 3 cycles per word, o_done in cycle 13.
